// File: rtl/mmio_uart_pkg.sv
//==============================================================================
// mmio_uart_pkg : register offsets, STATUS bit layout and serializer states
// Revision      : 1.0
//==============================================================================
`default_nettype none

package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
//==============================================================================
// mmio_uart_tx_if : processor data-memory bus seen by the UART register window
// Revision        : 1.0
//==============================================================================
`default_nettype none

interface mmio_uart_tx_if;
    logic [31:0] addr_rw;
    logic        we;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        hit;

    modport master (output addr_rw, we, data_w, input  data_r, hit);
    modport slave  (input  addr_rw, we, data_w, output data_r, hit);
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
//==============================================================================
// sync_fifo : single-clock FIFO; a push into a full FIFO is accepted when a pop
//             happens in the same cycle. Head is visible combinationally.
// Revision  : 1.0
//==============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     push_ok,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;

    assign full     = (r_count == c_cw'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({push_ok, pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
//==============================================================================
// mmio_uart_tx : memory-mapped UART transmitter (TX FIFO + 8N1 serializer)
// Revision     : 1.0
//==============================================================================
`default_nettype none

module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          irq_empty
);
    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    logic             w_hit;
    logic [1:0]       w_off;
    logic             w_wr;
    logic             w_push;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_full;
    logic             w_empty;
    logic [c_cw-1:0]  w_count;
    logic [7:0]       w_head;
    logic [31:0]      w_status;
    logic [31:0]      w_rdata;
    logic             w_unused;

    logic [15:0]      r_div;
    logic             r_ovf;

    tx_state_t        r_state, w_state_nxt;
    logic [15:0]      r_timer, w_timer_nxt;
    logic [15:0]      r_fdiv, w_fdiv_nxt;
    logic [2:0]       r_bitcnt, w_bitcnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_tx, w_tx_nxt;
    logic             r_irq;
    logic             w_tick;

    assign w_hit    = (bus.addr_rw[31:4] == BASE_ADDR[31:4]);
    assign w_off    = bus.addr_rw[3:2];
    assign w_wr     = bus.we && w_hit;
    assign w_push   = w_wr && (w_off == OFF_TXDATA);
    assign w_unused = ^{bus.data_w[31:16], bus.addr_rw[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (bus.data_w[7:0]),
        .pop       (w_pop),
        .pop_data  (w_head),
        .push_ok   (w_push_ok),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_status                                = '0;
        w_status[ST_FULL]                       = w_full;
        w_status[ST_EMPTY]                      = w_empty;
        w_status[ST_BUSY]                       = (r_state != S_IDLE);
        w_status[ST_OVF]                        = r_ovf;
        w_status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(w_count);
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_STATUS:  w_rdata = w_status;
                OFF_BAUDDIV: w_rdata = {16'd0, r_div};
                default:     w_rdata = '0;
            endcase
        end
    end

    assign bus.data_r = w_rdata;
    assign bus.hit    = w_hit;

    // A refused push sets overflow; the two events never share a cycle with a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= DEFAULT_DIV;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (w_off == OFF_BAUDDIV)) begin
                r_div <= (bus.data_w[15:0] == 16'd0) ? 16'd1 : bus.data_w[15:0];
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == OFF_STATUS) && bus.data_w[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_tick = (r_timer == 16'd1);

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_fdiv_nxt   = r_fdiv;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_pop        = 1'b0;
        w_tx_nxt     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_fdiv_nxt   = r_div;
                    w_timer_nxt  = r_div;
                    w_bitcnt_nxt = 3'd0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_tick) begin
                    w_timer_nxt = r_fdiv;
                    w_state_nxt = S_DATA;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_tick) begin
                    w_timer_nxt  = r_fdiv;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_timer  <= 16'd1;
            r_fdiv   <= 16'd1;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
            r_irq    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_fdiv   <= w_fdiv_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_irq    <= w_empty && (r_state == S_IDLE);
        end
    end

    assign tx        = r_tx;
    assign irq_empty = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
//==============================================================================
// tb_mmio_uart_tx : directed bench with a frame-level model of the UART
// Revision        : 1.0
//==============================================================================
`default_nettype none

module tb_mmio_uart_tx;

    localparam logic [31:0] c_base    = 32'hFFFF_0000;
    localparam logic [31:0] c_txdata  = c_base + 32'h0;
    localparam logic [31:0] c_status  = c_base + 32'h4;
    localparam logic [31:0] c_bauddiv = c_base + 32'h8;
    localparam logic [31:0] c_resv    = c_base + 32'hC;
    localparam int          c_depth   = 8;

    logic clk;
    logic reset;
    logic tx;
    logic irq_empty;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR   (c_base),
        .FIFO_DEPTH  (c_depth),
        .DEFAULT_DIV (16'd16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a byte queue plus "frame in flight" elapsed-cycle counter.
    logic [7:0]  q [$];
    logic        m_busy  = 1'b0;
    int          m_cnt   = 0;
    int          m_fdiv  = 1;
    logic [7:0]  m_fbyte = 8'h00;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_div   = 16'd16;
    logic        m_valid = 1'b0;
    logic        exp_tx  = 1'b1;
    logic        exp_irq = 1'b1;

    always @(posedge clk) begin
        int idx;
        logic m_hit;
        m_hit = (bus.addr_rw[31:4] == c_base[31:4]);
        if (reset) begin
            q.delete();
            m_busy  = 1'b0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_div   = 16'd16;
            exp_tx  = 1'b1;
            exp_irq = 1'b1;
            m_valid = 1'b1;
        end else begin
            exp_tx = 1'b1;
            if (m_busy) begin
                idx = m_cnt / m_fdiv;
                if (idx == 0)      exp_tx = 1'b0;
                else if (idx == 9) exp_tx = 1'b1;
                else               exp_tx = m_fbyte[idx-1];
            end
            exp_irq = (q.size() == 0) && !m_busy;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 10 * m_fdiv) m_busy = 1'b0;
            end else if (q.size() != 0) begin
                m_fbyte = q.pop_front();
                m_fdiv  = int'(m_div);
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
            if (bus.we && m_hit) begin
                case (bus.addr_rw[3:2])
                    2'd0: if (q.size() < c_depth) q.push_back(bus.data_w[7:0]);
                          else m_ovf = 1'b1;
                    2'd1: if (bus.data_w[3]) m_ovf = 1'b0;
                    2'd2: m_div = (bus.data_w[15:0] == 16'd0) ? 16'd1 : bus.data_w[15:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        logic [31:0] s;
        s = 32'd0;
        if (a[31:4] != c_base[31:4]) return 32'd0;
        case (a[3:2])
            2'd1: begin
                s[0]   = (q.size() == c_depth);
                s[1]   = (q.size() == 0);
                s[2]   = m_busy;
                s[3]   = m_ovf;
                s[8:4] = 5'(q.size());
                return s;
            end
            2'd2:    return {16'd0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx", {31'd0, tx}, {31'd0, exp_tx});
            chk("irq_empty", {31'd0, irq_empty}, {31'd0, exp_irq});
            chk("hit", {31'd0, bus.hit}, {31'd0, (bus.addr_rw[31:4] == c_base[31:4])});
            chk("data_r", bus.data_r, model_rdata(bus.addr_rw));
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        bus.addr_rw = a; bus.we = 1'b1; bus.data_w = d;
    endtask

    task automatic bus_idle();
        @(posedge clk); #2;
        bus.addr_rw = c_status; bus.we = 1'b0; bus.data_w = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(posedge clk); #2;
        bus.we = 1'b0; bus.addr_rw = a; bus.data_w = 32'd0;
        #1;
        d = bus.data_r;
        h = bus.hit;
    endtask

    task automatic wait_drain(input string name, input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk); #1;
            if (irq_empty === 1'b1 && q.size() == 0 && !m_busy) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        h;
        logic [9:0]  bits55;
        int          n;
        logic        got;

        reset = 1'b1;
        bus.addr_rw = c_status; bus.we = 1'b0; bus.data_w = 32'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Reset register values and window decode
        rd(c_status, d, h);   chk("status_reset", d, 32'h0000_0002);
        rd(c_bauddiv, d, h);  chk("bauddiv_reset", d, 32'd16);
        rd(32'h1000_0004, d, h);
        chk("outside_hit", {31'd0, h}, 32'd0);
        chk("outside_data", d, 32'd0);
        wr(c_resv, 32'hFFFF_FFFF);
        rd(c_resv, d, h);     chk("reserved_read", d, 32'd0);
        rd(c_txdata, d, h);   chk("txdata_read", d, 32'd0);

        // Single 0x55 frame at div 4: start bit, LSB-first data, stop bit
        wr(c_bauddiv, 32'd4);
        wr(c_txdata, 32'h55);
        bus_idle();
        bits55 = 10'b1_0101_0101_0;
        repeat (2) @(posedge clk);
        for (int b = 0; b < 10; b++) begin
            repeat (2) @(posedge clk);
            #1 chk($sformatf("frame55_bit%0d", b), {31'd0, tx}, {31'd0, bits55[b]});
            repeat (2) @(posedge clk);
        end
        #1 chk("irq_after_frame", {31'd0, irq_empty}, 32'd1);

        // Nine back-to-back bytes at div 2; the first pop makes room for the ninth
        wr(c_bauddiv, 32'd2);
        for (int i = 1; i <= 9; i++) wr(c_txdata, 32'(i));
        bus_idle();
        wait_drain("drain_nine", 400);
        rd(c_status, d, h);   chk("status_after_nine", d, 32'h0000_0002);

        // Overflow: busy serializer, fill to eight, ninth dropped
        wr(c_bauddiv, 32'd8);
        wr(c_txdata, 32'hA0);
        for (int i = 1; i <= 9; i++) wr(c_txdata, 32'hA0 + 32'(i));
        rd(c_status, d, h);   chk("status_overflow", d, 32'h0000_008D);
        wr(c_status, 32'h8);
        rd(c_status, d, h);   chk("status_ovf_cleared", d, 32'h0000_0085);

        // Push while full lands on the same edge as the next pop
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #2;
            if (!m_busy) got = 1'b1;
        end
        chk("pop_slot_found", {31'd0, got}, 32'd1);
        bus.addr_rw = c_txdata; bus.we = 1'b1; bus.data_w = 32'h77;
        bus_idle();
        rd(c_status, d, h);   chk("status_push_on_pop", d, 32'h0000_0085);
        wait_drain("drain_full", 1500);

        // Divider 0 is stored as 1: frame is 10 cycles, irq back 12 edges after the write
        wr(c_bauddiv, 32'd0);
        rd(c_bauddiv, d, h);  chk("bauddiv_zero", d, 32'd1);
        wr(c_txdata, 32'hA5);
        bus_idle();
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (irq_empty !== 1'b1 && n < 50);
        chk("div1_irq_latency", 32'(n), 32'd12);

        // Reset in the middle of DATA
        wr(c_bauddiv, 32'd4);
        wr(c_txdata, 32'hF0);
        bus_idle();
        repeat (8) @(posedge clk);
        #1 chk("mid_data_tx", {31'd0, tx}, 32'd0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk("tx_after_reset", {31'd0, tx}, 32'd1);
        #1 reset = 1'b0;
        rd(c_status, d, h);   chk("status_after_reset", d, 32'h0000_0002);
        rd(c_bauddiv, d, h);  chk("bauddiv_after_reset", d, 32'd16);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
